// File: rtl/alu_ex_stage_pkg.sv
// rtl/alu_ex_stage_pkg.sv - shared widths and ALU control codes for the execute stage
package alu_ex_stage_pkg;
  localparam int WIDTH = 32;
  localparam int REG_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: add/sub/and/or/slt with zero, overflow and illegal-code flags
module alu_core
  import alu_ex_stage_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluCtr,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (aluCtr)
      ALU_ADD: begin
        result   = a + b;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        // Subtraction adds ~b, so overflow needs the operand signs to differ.
        result   = a - b;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - execute stage: operand forwarding, load-use stall and the EX/MEM register
module alu_ex_stage
  import alu_ex_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       aluCtr,
  input  logic [WIDTH-1:0] rsData,
  input  logic [WIDTH-1:0] rtData,
  input  logic [WIDTH-1:0] imm,
  input  logic             aluSrc,
  input  logic [REG_W-1:0] rsAddr,
  input  logic [REG_W-1:0] rtAddr,
  input  logic [REG_W-1:0] destAddr,
  input  logic             regWrite,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic             wbRegWrite,
  input  logic [REG_W-1:0] wbAddr,
  input  logic [WIDTH-1:0] wbData,
  input  logic             flush,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outResult,
  output logic [WIDTH-1:0] outStoreData,
  output logic [REG_W-1:0] outDest,
  output logic             outRegWrite,
  output logic             outMemRead,
  output logic             outMemWrite,
  output logic             outZero,
  output logic             outOverflow,
  output logic             outIllegal
);

  logic             exFwdOk, wbFwdOk, loadUse, accept;
  logic [WIDTH-1:0] fwdA, fwdB, opB, aluResult;
  logic             aluZero, aluOverflow, aluIllegal;

  // A load's result is not known until MEM, so it never forwards from EX/MEM.
  assign exFwdOk = outValid && outRegWrite && !outMemRead && (outDest != '0);
  assign wbFwdOk = wbRegWrite && (wbAddr != '0);

  assign fwdA = (exFwdOk && outDest == rsAddr) ? outResult :
                (wbFwdOk && wbAddr == rsAddr)  ? wbData    : rsData;
  assign fwdB = (exFwdOk && outDest == rtAddr) ? outResult :
                (wbFwdOk && wbAddr == rtAddr)  ? wbData    : rtData;
  assign opB  = aluSrc ? imm : fwdB;

  assign loadUse = outValid && outMemRead && (outDest != '0) &&
                   ((outDest == rsAddr) || (outDest == rtAddr)) && inValid;
  assign inReady = (!outValid || outReady) && !loadUse;
  assign accept  = inValid && inReady;

  alu_core uCore (
    .a        (fwdA),
    .b        (opB),
    .aluCtr   (aluCtr),
    .result   (aluResult),
    .zero     (aluZero),
    .overflow (aluOverflow),
    .illegal  (aluIllegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid     <= 1'b0;
      outResult    <= '0;
      outStoreData <= '0;
      outDest      <= '0;
      outRegWrite  <= 1'b0;
      outMemRead   <= 1'b0;
      outMemWrite  <= 1'b0;
      outZero      <= 1'b0;
      outOverflow  <= 1'b0;
      outIllegal   <= 1'b0;
    end else if (accept) begin
      outValid <= !flush;
      if (!flush) begin
        outResult    <= aluResult;
        outStoreData <= fwdB;
        outDest      <= destAddr;
        outRegWrite  <= regWrite && !aluIllegal;
        outMemRead   <= memRead && !aluIllegal;
        outMemWrite  <= memWrite && !aluIllegal;
        outZero      <= aluZero;
        outOverflow  <= aluOverflow;
        outIllegal   <= aluIllegal;
      end
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - self-checking bench for alu_ex_stage with a behavioural reference model
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid, inReady;
  logic [3:0]  aluCtr;
  logic [31:0] rsData, rtData, imm, wbData;
  logic        aluSrc;
  logic [4:0]  rsAddr, rtAddr, destAddr, wbAddr;
  logic        regWrite, memRead, memWrite, wbRegWrite, flush;
  logic        outValid, outReady;
  logic [31:0] outResult, outStoreData;
  logic [4:0]  outDest;
  logic        outRegWrite, outMemRead, outMemWrite, outZero, outOverflow, outIllegal;

  int compared = 0;
  int mismatched = 0;

  // Model of what EX/MEM should hold, used by the randomized test.
  logic        mValid, mRegWrite;
  logic [4:0]  mDest;
  logic [31:0] mResult;

  always #5 clk = ~clk;

  alu_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .aluCtr(aluCtr),
    .rsData(rsData), .rtData(rtData), .imm(imm), .aluSrc(aluSrc),
    .rsAddr(rsAddr), .rtAddr(rtAddr), .destAddr(destAddr),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .wbRegWrite(wbRegWrite), .wbAddr(wbAddr), .wbData(wbData), .flush(flush),
    .outValid(outValid), .outReady(outReady), .outResult(outResult),
    .outStoreData(outStoreData), .outDest(outDest), .outRegWrite(outRegWrite),
    .outMemRead(outMemRead), .outMemWrite(outMemWrite), .outZero(outZero),
    .outOverflow(outOverflow), .outIllegal(outIllegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    inValid = 0; aluCtr = 4'b0010; rsData = 0; rtData = 0; imm = 0; aluSrc = 0;
    rsAddr = 0; rtAddr = 0; destAddr = 0; regWrite = 0; memRead = 0; memWrite = 0;
    wbRegWrite = 0; wbAddr = 0; wbData = 0; flush = 0; outReady = 1;
  endtask

  task automatic beat(input logic [3:0] c, input logic [4:0] rsA, input logic [4:0] rtA,
                      input logic [4:0] dst, input logic [31:0] rsD, input logic [31:0] rtD,
                      input logic [31:0] immV, input logic src, input logic rw,
                      input logic mr, input logic mw);
    inValid = 1; aluCtr = c; rsAddr = rsA; rtAddr = rtA; destAddr = dst;
    rsData = rsD; rtData = rtD; imm = immV; aluSrc = src;
    regWrite = rw; memRead = mr; memWrite = mw;
  endtask

  // Reference ALU from arithmetic on wide signed integers.
  function automatic void refAlu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ov, output logic ill);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0; ov = 0; ill = 0;
    case (c)
      4'b0010: begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: ill = 1;
    endcase
  endfunction

  task automatic test_reset();
    setIdle();
    rst_n = 0;
    beat(4'b0010, 1, 2, 3, 32'h11, 32'h22, 0, 0, 1, 1, 1);
    step();
    setIdle();
    #1;
    if ({outValid, outResult, outStoreData, outDest, outRegWrite, outMemRead, outMemWrite,
         outZero, outOverflow, outIllegal} !== '0) begin
      mismatched++;
      $display("FAIL reset_outs: got valid=%0b result=%h dest=%0d", outValid, outResult, outDest);
    end
    compared++;
    if (inReady !== 1'b1) begin mismatched++; $display("FAIL reset_inReady: got %b want 1", inReady); end
    compared++;
    rst_n = 1;
    step();
  endtask

  task automatic test_add_overflow();
    beat(4'b0010, 1, 2, 3, 32'h7FFFFFFF, 32'h1, 0, 0, 1, 0, 0);
    step();
    setIdle();
    if (outValid !== 1'b1) begin mismatched++; $display("FAIL add_valid: got %b want 1", outValid); end
    compared++;
    if (outResult !== 32'h80000000) begin mismatched++; $display("FAIL add_result: got %h want 80000000", outResult); end
    compared++;
    if (outOverflow !== 1'b1 || outZero !== 1'b0) begin
      mismatched++; $display("FAIL add_flags: got ov=%b zero=%b want ov=1 zero=0", outOverflow, outZero);
    end
    compared++;
    step();
  endtask

  task automatic test_sub_slt();
    beat(4'b0110, 1, 2, 5, 32'd5, 32'd5, 0, 0, 1, 0, 0);
    step();
    beat(4'b0111, 6, 7, 8, 32'hFFFFFFFF, 32'd1, 0, 0, 1, 0, 0);
    if (outResult !== 32'd0 || outZero !== 1'b1 || outOverflow !== 1'b0) begin
      mismatched++; $display("FAIL sub_zero: got result=%h zero=%b ov=%b want 0/1/0", outResult, outZero, outOverflow);
    end
    compared++;
    step();
    setIdle();
    if (outResult !== 32'd1 || outDest !== 5'd8) begin
      mismatched++; $display("FAIL slt_signed: got result=%h dest=%0d want 1/8", outResult, outDest);
    end
    compared++;
    step();
  endtask

  task automatic test_forward_priority();
    beat(4'b0010, 1, 2, 3, 32'd10, 32'd20, 0, 0, 1, 0, 0);
    step();
    beat(4'b0000, 3, 9, 10, 32'h55, 32'hFF, 0, 0, 1, 0, 0);
    wbRegWrite = 1; wbAddr = 3; wbData = 32'h0F;
    step();
    if (outResult !== 32'h1E || outStoreData !== 32'hFF) begin
      mismatched++; $display("FAIL fwd_ex_priority: got result=%h store=%h want 1e/ff", outResult, outStoreData);
    end
    compared++;
    beat(4'b0001, 7, 0, 11, 32'd0, 32'd0, 0, 0, 1, 0, 0);
    wbRegWrite = 1; wbAddr = 7; wbData = 32'h100;
    step();
    setIdle();
    if (outResult !== 32'h100) begin mismatched++; $display("FAIL fwd_wb: got %h want 100", outResult); end
    compared++;
    step();
  endtask

  task automatic test_load_use();
    beat(4'b0010, 1, 0, 4, 32'h100, 32'd0, 32'd8, 1, 1, 1, 0);
    step();
    if (outMemRead !== 1'b1 || outResult !== 32'h108) begin
      mismatched++; $display("FAIL load_beat: got memRead=%b result=%h want 1/108", outMemRead, outResult);
    end
    compared++;
    beat(4'b0010, 4, 5, 6, 32'd0, 32'd2, 0, 0, 1, 0, 0);
    #1;
    if (inReady !== 1'b0) begin mismatched++; $display("FAIL load_use_stall: got inReady=%b want 0", inReady); end
    compared++;
    step();
    wbRegWrite = 1; wbAddr = 4; wbData = 32'd40;
    #1;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      mismatched++; $display("FAIL load_use_release: got inReady=%b outValid=%b want 1/0", inReady, outValid);
    end
    compared++;
    step();
    setIdle();
    if (outValid !== 1'b1 || outResult !== 32'd42) begin
      mismatched++; $display("FAIL load_use_result: got valid=%b result=%0d want 1/42", outValid, outResult);
    end
    compared++;
    step();
  endtask

  task automatic test_hold();
    int okCycles = 0;
    beat(4'b0010, 1, 2, 10, 32'd1, 32'd2, 0, 0, 1, 0, 0);
    step();
    beat(4'b0010, 4, 5, 11, 32'd4, 32'd5, 0, 0, 1, 0, 0);
    outReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (inReady === 1'b0 && outValid === 1'b1 && outResult === 32'd3 && outDest === 5'd10) okCycles++;
      step();
    end
    if (okCycles !== 3) begin mismatched++; $display("FAIL hold_stable: got %0d stable cycles want 3", okCycles); end
    compared++;
    outReady = 1;
    #1;
    if (inReady !== 1'b1) begin mismatched++; $display("FAIL hold_release: got inReady=%b want 1", inReady); end
    compared++;
    step();
    setIdle();
    if (outValid !== 1'b1 || outResult !== 32'd9 || outDest !== 5'd11) begin
      mismatched++; $display("FAIL hold_next_beat: got valid=%b result=%0d dest=%0d want 1/9/11", outValid, outResult, outDest);
    end
    compared++;
    step();
    if (outValid !== 1'b0) begin mismatched++; $display("FAIL hold_no_dup: got outValid=%b want 0", outValid); end
    compared++;
  endtask

  task automatic test_flush();
    beat(4'b0010, 1, 2, 3, 32'd1, 32'd1, 0, 0, 1, 0, 0);
    step();
    beat(4'b0010, 1, 2, 3, 32'd7, 32'd7, 0, 0, 1, 0, 0);
    flush = 1;
    step();
    if (outValid !== 1'b0) begin mismatched++; $display("FAIL flush_accept: got outValid=%b want 0", outValid); end
    compared++;
    flush = 0;
    step();
    outReady = 0; flush = 1;
    step();
    if (outValid !== 1'b1 || outResult !== 32'd14) begin
      mismatched++; $display("FAIL flush_in_hold: got valid=%b result=%0d want 1/14", outValid, outResult);
    end
    compared++;
    setIdle();
    step();
  endtask

  task automatic test_illegal();
    beat(4'b1111, 1, 2, 3, 32'd5, 32'd6, 0, 0, 1, 1, 1);
    step();
    setIdle();
    if (outValid !== 1'b1 || outIllegal !== 1'b1 || outResult !== 32'd0) begin
      mismatched++; $display("FAIL illegal_flag: got valid=%b illegal=%b result=%h want 1/1/0", outValid, outIllegal, outResult);
    end
    compared++;
    if (outRegWrite !== 1'b0 || outMemRead !== 1'b0 || outMemWrite !== 1'b0) begin
      mismatched++; $display("FAIL illegal_ctrl: got rw=%b mr=%b mw=%b want 0/0/0", outRegWrite, outMemRead, outMemWrite);
    end
    compared++;
    step();
  endtask

  task automatic test_reset_midstream();
    beat(4'b0010, 1, 2, 3, 32'd9, 32'd9, 0, 0, 1, 0, 1);
    step();
    outReady = 0;
    rst_n = 0;
    step();
    if ({outValid, outResult, outStoreData, outDest, outRegWrite, outMemWrite, outZero} !== '0) begin
      mismatched++; $display("FAIL reset_midstream: got valid=%b result=%h dest=%0d want all 0", outValid, outResult, outDest);
    end
    compared++;
    rst_n = 1;
    setIdle();
    step();
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a, b, bf, r;
    logic        ov, ill;
    logic [3:0]  codes [6];
    codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1010};
    setIdle();
    step();
    mValid = 0; mRegWrite = 0; mDest = 0; mResult = 0;
    for (int i = 0; i < 80; i++) begin
      c = codes[$urandom_range(0, 5)];
      beat(c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      if (($urandom_range(0, 3) == 0)) begin rsData = 32'h7FFFFFFF; rtData = 32'h80000000; end
      wbRegWrite = 1'($urandom_range(0, 1)); wbAddr = 5'($urandom_range(0, 3)); wbData = $urandom;
      // Architecturally newest value of each source register.
      if (mValid && mRegWrite && mDest != 0 && mDest == rsAddr) a = mResult;
      else if (wbRegWrite && wbAddr != 0 && wbAddr == rsAddr) a = wbData;
      else a = rsData;
      if (mValid && mRegWrite && mDest != 0 && mDest == rtAddr) bf = mResult;
      else if (wbRegWrite && wbAddr != 0 && wbAddr == rtAddr) bf = wbData;
      else bf = rtData;
      b = aluSrc ? imm : bf;
      refAlu(c, a, b, r, ov, ill);
      #1;
      if (inReady !== 1'b1) begin mismatched++; $display("FAIL rand_inReady[%0d]: got %b want 1", i, inReady); end
      compared++;
      step();
      if (outValid !== 1'b1 || outResult !== r || outStoreData !== bf) begin
        mismatched++;
        $display("FAIL rand_data[%0d]: got valid=%b result=%h store=%h want 1/%h/%h", i, outValid, outResult, outStoreData, r, bf);
      end
      compared++;
      if (outOverflow !== ov || outIllegal !== ill || outZero !== (r == 0) || outRegWrite !== (regWrite && !ill)) begin
        mismatched++;
        $display("FAIL rand_flags[%0d]: got ov=%b ill=%b zero=%b rw=%b want %b/%b/%b/%b", i,
                 outOverflow, outIllegal, outZero, outRegWrite, ov, ill, (r == 0), (regWrite && !ill));
      end
      compared++;
      mValid = 1; mDest = destAddr; mRegWrite = regWrite && !ill; mResult = r;
    end
    setIdle();
    step();
  endtask

  initial begin
    setIdle();
    rst_n = 0;
    test_reset();
    test_add_overflow();
    test_sub_slt();
    test_forward_priority();
    test_load_use();
    test_hold();
    test_flush();
    test_illegal();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute stage of the MIPS pipeline: accepts one decoded instruction per cycle, takes the 4-bit ALU control code from the ALU-control decoder, forwards operands, computes result, zero and overflow, and registers everything into the EX/MEM pipeline register. A valid/ready handshake on both sides provides back-pressure. The stage inserts a one-cycle load-use stall and supports a synchronous flush.

## Interface
- WIDTH, 32, datapath width
- REG_W, 5, register-address width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- inValid  in  1  upstream beat valid
- inReady  out  1  stage can accept this cycle
- aluCtr  in  4  ALU control code: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- rsData, rtData  in  WIDTH  register-file read data
- imm  in  WIDTH  sign-extended immediate
- aluSrc  in  1  1 selects imm as operand B
- rsAddr, rtAddr, destAddr  in  REG_W  source and destination register numbers
- regWrite, memRead, memWrite  in  1  control bits carried to MEM
- wbRegWrite  in  1  write-back stage writes a register
- wbAddr  in  REG_W  write-back destination
- wbData  in  WIDTH  write-back data
- flush  in  1  kill the beat entering EX this cycle
- outValid  out  1  EX/MEM holds a valid instruction
- outReady  in  1  MEM stage accepts
- outResult, outStoreData  out  WIDTH  ALU result; forwarded rt value
- outDest  out  REG_W  destination register
- outRegWrite, outMemRead, outMemWrite, outZero, outOverflow, outIllegal  out  1  registered control and flags

## Operation
- Forwarding per source (rs, rt), priority high to low:
  - own EX/MEM register, when outValid && outRegWrite && !outMemRead && outDest != 0 && outDest == src
  - write-back, when wbRegWrite && wbAddr != 0 && wbAddr == src
  - register-file data
- Operand A = forwarded rs. Operand B = aluSrc ? imm : forwarded rt. outStoreData = forwarded rt.
- Load-use stall: inReady = 0 when outValid && outMemRead && outDest != 0 && (outDest == rsAddr || outDest == rtAddr) && inValid. The stall clears once the load leaves EX/MEM; its data then arrives through the wb inputs.
- Operations:
  - add/sub: modulo 2^WIDTH. outOverflow = signed overflow (operand signs equal and result sign differs, with B inverted for sub); 0 for all other operations.
  - and, or: bitwise.
  - slt: signed compare; result is 1 or 0, zero-extended.
- Any other aluCtr: result 0, outIllegal = 1, regWrite/memRead/memWrite forced to 0. outValid still asserts.
- outZero = (result == 0).

## Timing
- Reset (rst_n low at an edge): outValid and every out* register become 0. inReady reads 1 after reset unless a stall condition holds.
- inReady = (!outValid || outReady) && !loadUse.
- Accept happens when inValid && inReady; outputs update at that edge, so latency is 1 cycle. Throughput is 1 per cycle.
- Hold: when outValid && !outReady, all out* stay stable and inReady = 0.
- Flush: when flush && inValid && inReady, the beat is consumed but discarded and outValid becomes 0. If MEM consumes in the same cycle, the old beat leaves normally.
- Flush during a stall has no effect on EX/MEM; upstream owns the stalled beat.
- Neither side accepting: state unchanged.
- Reset during a stall or hold drops the held beat.

## Structure
- A shared package holds the ALU control code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), WIDTH, and REG_W.
- One combinational sub-module, alu_core (a, b, aluCtr → result, zero, overflow, illegal).
- Forwarding, hazard detection and the EX/MEM register stay in alu_ex_stage.

## Test plan
- add 0x7FFFFFFF + 0x00000001, aluSrc=0 → one cycle later outResult=0x80000000, outOverflow=1, outZero=0.
- sub 5 − 5 → outResult=0, outZero=1. slt with rs=0xFFFFFFFF, rt=1 → outResult=1.
- Back-to-back add writing r3, then and reading r3 while wb also writes r3=0x0F → the and uses the EX/MEM value, not 0x0F.
- Load to r4 followed by add reading r4 → inReady=0 for one cycle; the add takes r4 from the wb inputs and completes one cycle later.
- outReady held low for 3 cycles with inValid=1 → out* stable, inReady=0 throughout, no beat lost or duplicated.
- flush on accept → outValid=0 next cycle. aluCtr=1111 → outIllegal=1, outRegWrite=0. rst_n low mid-stream → all outputs 0 next edge.
